// File: rtl/dot_product_loader.sv
// Assembles a serial stream of (a, b) pairs into LANES-wide vectors, runs the dot-product stage and
// hands its result downstream. Defining DOT_LOADER_TIMEOUT_EN adds a watchdog on the WAIT state.
module dot_product_loader #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned LANES          = 8,
  parameter int unsigned RES_W          = 64,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_a,
  input  logic [DATA_W-1:0]           in_b,
  input  logic                        in_last,
  output logic                        dp_start,
  output logic [LANES*DATA_W-1:0]     dp_a,
  output logic [LANES*DATA_W-1:0]     dp_b,
  input  logic                        dp_done,
  input  logic [RES_W-1:0]            dp_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [RES_W-1:0]            out_result,
  output logic [$clog2(LANES+1)-1:0]  out_count,
  output logic                        out_error
);

  localparam int unsigned CNT_W = $clog2(LANES + 1);
  localparam int unsigned VEC_W = LANES * DATA_W;

  if (TIMEOUT_CYCLES == 0 || LANES == 0) begin : g_param_chk
    $error("dot_product_loader: LANES and TIMEOUT_CYCLES must be nonzero");
  end

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [VEC_W-1:0]   a_q, a_d, b_q, b_d;
  logic               in_ready_d, dp_start_d, out_valid_d;
  logic [RES_W-1:0]   out_result_d;
  logic [CNT_W-1:0]   out_count_d;
  int unsigned        lane_base;

`ifdef DOT_LOADER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]   wait_q, wait_d;
  logic               out_error_d;
`endif

  assign dp_a = a_q;
  assign dp_b = b_q;

  // Next-state and next-output logic; every registered value defaults to hold
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    a_d          = a_q;
    b_d          = b_q;
    in_ready_d   = in_ready;
    dp_start_d   = 1'b0;
    out_valid_d  = out_valid;
    out_result_d = out_result;
    out_count_d  = out_count;
    lane_base    = 32'(count_q) * DATA_W;
`ifdef DOT_LOADER_TIMEOUT_EN
    wait_d       = wait_q;
    out_error_d  = out_error;
`endif
    unique case (state_q)
      FILL: begin
        if (in_valid && in_ready) begin
          a_d[lane_base +: DATA_W] = in_a;
          b_d[lane_base +: DATA_W] = in_b;
          count_d = count_q + CNT_W'(1);
          if (in_last || count_q == CNT_W'(LANES - 1)) begin
            state_d    = START;
            in_ready_d = 1'b0;
            dp_start_d = 1'b1;
          end
        end
      end
      START: begin
        state_d = WAIT;
`ifdef DOT_LOADER_TIMEOUT_EN
        wait_d  = '0;
`endif
      end
      WAIT: begin
        // A done arriving in the expiry cycle takes priority over the watchdog
        if (dp_done) begin
          out_result_d = dp_result;
          out_count_d  = count_q;
          out_valid_d  = 1'b1;
          state_d      = OUT;
`ifdef DOT_LOADER_TIMEOUT_EN
          out_error_d  = 1'b0;
        end else if (wait_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          out_result_d = '0;
          out_count_d  = count_q;
          out_valid_d  = 1'b1;
          out_error_d  = 1'b1;
          state_d      = OUT;
        end else begin
          wait_d = wait_q + TMO_W'(1);
`endif
        end
      end
      OUT: begin
        if (out_ready) begin
          a_d         = '0;
          b_d         = '0;
          count_d     = '0;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = FILL;
`ifdef DOT_LOADER_TIMEOUT_EN
          out_error_d = 1'b0;
`endif
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FILL;
      count_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      in_ready   <= 1'b1;
      dp_start   <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_count  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      a_q        <= a_d;
      b_q        <= b_d;
      in_ready   <= in_ready_d;
      dp_start   <= dp_start_d;
      out_valid  <= out_valid_d;
      out_result <= out_result_d;
      out_count  <= out_count_d;
    end
  end

`ifdef DOT_LOADER_TIMEOUT_EN
  // Watchdog counter and error flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_q    <= '0;
      out_error <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      out_error <= out_error_d;
    end
  end
`else
  assign out_error = 1'b0;
`endif

endmodule

// File: tb/tb_dot_product_loader.sv
// Scoreboard bench for dot_product_loader: directed vectors push expected results, a monitor checks
// each output handshake. A small registered dot-product model stands in for the downstream stage.
module tb_dot_product_loader;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 8;
  localparam int unsigned RES_W  = 64;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned VEC_W  = LANES * DATA_W;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [DATA_W-1:0]  in_a = '0, in_b = '0;
  logic               dp_start, dp_done;
  logic [VEC_W-1:0]   dp_a, dp_b;
  logic [RES_W-1:0]   dp_result;
  logic               out_valid, out_ready = 1'b1, out_error;
  logic [RES_W-1:0]   out_result;
  logic [CNT_W-1:0]   out_count;

  typedef struct packed {
    logic [RES_W-1:0] result;
    logic [CNT_W-1:0] count;
    logic             err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   starts = 0;
  logic dp_en  = 1'b1;

  dot_product_loader #(.DATA_W(DATA_W), .LANES(LANES), .RES_W(RES_W), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .dp_start(dp_start), .dp_a(dp_a), .dp_b(dp_b), .dp_done(dp_done), .dp_result(dp_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_count(out_count), .out_error(out_error)
  );

  always #5 clock = ~clock;

  function automatic logic [RES_W-1:0] dot(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
    logic [RES_W-1:0] s;
    s = '0;
    for (int i = 0; i < LANES; i++)
      s += RES_W'(a[i*DATA_W +: DATA_W]) * RES_W'(b[i*DATA_W +: DATA_W]);
    return s;
  endfunction

  // Downstream stand-in: done one cycle after start
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dp_done   <= 1'b0;
      dp_result <= '0;
    end else begin
      dp_done   <= dp_start && dp_en;
      dp_result <= dot(dp_a, dp_b);
    end
  end

  always @(posedge clock) if (reset_n && dp_start) starts++;

  task automatic check(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic [RES_W-1:0] r, input logic [CNT_W-1:0] c, input logic e);
    exp_t x;
    x.result = r;
    x.count  = c;
    x.err    = e;
    sb.push_back(x);
  endtask

  // Monitor: compare every completed output handshake against the scoreboard
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result %0d with no expected entry", out_result);
      end else begin
        mon_e = sb.pop_front();
        check("out_result", out_result, mon_e.result);
        check("out_count", RES_W'(out_count), RES_W'(mon_e.count));
        check("out_error", RES_W'(out_error), RES_W'(mon_e.err));
      end
    end
  end

  task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic last);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_last = last;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
    end
  endtask

  task automatic wait_out(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!out_valid && n < limit);
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_out_timeout: got out_valid=0 expected 1 within %0d cycles", limit);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", RES_W'(out_valid), 0);
    check("rst_dp_start", RES_W'(dp_start), 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_count", RES_W'(out_count), 0);
    check("rst_out_error", RES_W'(out_error), 0);
    check("rst_dp_a_zero", RES_W'(dp_a == '0), 1);
    next_cycle();
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_in_ready", RES_W'(in_ready), 1);
    next_cycle();

    // Full vector with latency check
    expect_out(72, 8, 1'b0);
    for (int i = 0; i < 8; i++) send(DATA_W'(i + 1), 2, 1'b0);
    @(negedge clock);
    check("full_dp_start", RES_W'(dp_start), 1);
    check("full_dp_a_lane7", RES_W'(dp_a[7*DATA_W +: DATA_W]), 8);
    check("full_in_ready_start", RES_W'(in_ready), 0);
    @(negedge clock);
    check("full_dp_start_pulse", RES_W'(dp_start), 0);
    check("full_valid_early", RES_W'(out_valid), 0);
    @(negedge clock);
    check("full_valid_t3", RES_W'(out_valid), 1);
    next_cycle();

    // Short vector padded with zeros
    expect_out(105, 3, 1'b0);
    send(5, 7, 1'b0);
    send(5, 7, 1'b0);
    send(5, 7, 1'b1);
    @(negedge clock);
    check("short_dp_start", RES_W'(dp_start), 1);
    check("short_lane2_a", RES_W'(dp_a[2*DATA_W +: DATA_W]), 5);
    check("short_pad_a", RES_W'(dp_a[VEC_W-1:3*DATA_W] == '0), 1);
    check("short_pad_b", RES_W'(dp_b[VEC_W-1:3*DATA_W] == '0), 1);
    wait_out(10, n);
    next_cycle();

    // Output backpressure
    out_ready = 1'b0;
    expect_out(32, 8, 1'b0);
    for (int i = 0; i < 8; i++) send(2, 2, 1'b0);
    wait_out(10, n);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("bp_out_valid", RES_W'(out_valid), 1);
      check("bp_out_result", out_result, 32);
      check("bp_out_count", RES_W'(out_count), 8);
      check("bp_in_ready", RES_W'(in_ready), 0);
    end
    next_cycle();
    out_ready = 1'b1;
    @(negedge clock);
    check("bp_in_ready_hs", RES_W'(in_ready), 0);
    @(negedge clock);
    check("bp_in_ready_after", RES_W'(in_ready), 1);
    check("bp_valid_after", RES_W'(out_valid), 0);
    next_cycle();

    // Input stalls with junk data on idle cycles
    expect_out(8, 8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send(1, 1, 1'b0);
      in_a = 99;
      in_b = 99;
      next_cycle();
    end
    wait_out(20, n);
    next_cycle();

    // Reset during fill discards the partial vector
    for (int i = 0; i < 4; i++) send(9, 9, 1'b0);
    reset_n = 1'b0;
    @(negedge clock);
    check("mid_rst_out_valid", RES_W'(out_valid), 0);
    check("mid_rst_out_result", out_result, 0);
    check("mid_rst_out_count", RES_W'(out_count), 0);
    check("mid_rst_dp_a_zero", RES_W'(dp_a == '0), 1);
    check("mid_rst_dp_b_zero", RES_W'(dp_b == '0), 1);
    next_cycle();
    reset_n = 1'b1;
    @(negedge clock);
    check("mid_rst_in_ready", RES_W'(in_ready), 1);
    next_cycle();
    expect_out(72, 8, 1'b0);
    for (int i = 0; i < 8; i++) send(3, 3, 1'b0);
    wait_out(10, n);
    next_cycle();

    // Stage never answers
    dp_en = 1'b0;
    for (int i = 0; i < 8; i++) send(1, 1, 1'b0);
`ifdef DOT_LOADER_TIMEOUT_EN
    expect_out(0, 8, 1'b1);
    wait_out(40, n);
    check("wd_latency", RES_W'(n), 18);
    next_cycle();
`else
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      check("wd_off_valid", RES_W'(out_valid), 0);
      check("wd_off_error", RES_W'(out_error), 0);
    end
    next_cycle();
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
`endif
    dp_en = 1'b1;
    repeat (3) next_cycle();

    check("start_pulses", RES_W'(starts), 6);
    check("scoreboard_empty", RES_W'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_product_loader.md
Name: dot_product_loader

Overview:
- Upstream feeder for the 8-lane dot-product stage.
- Accepts a serial stream of (a, b) element pairs over a valid/ready handshake and assembles them into 8-lane A and B vectors.
- Pulses the stage's start, waits for its done, captures the 64-bit result and presents it on a valid/ready output handshake.
- Short vectors (early in_last) are zero-padded.

Parameters:
- DATA_W, 32, element width; must match the dot-product stage operand width.
- LANES, 8, vector length; must match the dot-product stage lane count.
- RES_W, 64, result width.
- TIMEOUT_CYCLES, 16, WAIT-state watchdog limit; used only with DOT_LOADER_TIMEOUT_EN.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  element pair present.
- in_ready  out  1  loader accepts an element this cycle.
- in_a  in  DATA_W  A element.
- in_b  in  DATA_W  B element.
- in_last  in  1  final element of the current vector.
- dp_start  out  1  one-cycle start pulse to the dot-product stage.
- dp_a  out  LANES*DATA_W  packed A vector; lane i at [i*DATA_W +: DATA_W].
- dp_b  out  LANES*DATA_W  packed B vector, same packing.
- dp_done  in  1  done from the dot-product stage.
- dp_result  in  RES_W  result from the dot-product stage.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_result  out  RES_W  captured result.
- out_count  out  $clog2(LANES+1)  number of real (non-padded) elements in the vector.
- out_error  out  1  watchdog expired; see Optional Feature.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State=FILL, count=0, all lanes=0.
  - dp_start=0, out_valid=0, out_result=0, out_count=0, out_error=0.
  - in_ready=1 as soon as reset is released.
- States: FILL -> START -> WAIT -> OUT -> FILL.
- FILL:
  - in_ready=1.
  - An accept (in_valid && in_ready) writes in_a/in_b into lane[count] and increments count.
  - Go to START on the accept where count==LANES-1 or in_last==1.
  - Unwritten lanes stay 0, so padding contributes 0 to the sum.
  - in_last on the LANES-th element is equivalent to completion without in_last.
- START:
  - dp_start=1 for exactly this cycle; in_ready=0.
  - Record the accepted element count (1..LANES).
  - Go to WAIT.
- WAIT:
  - in_ready=0.
  - On dp_done=1: capture dp_result into out_result and the count into out_count, then go to OUT.
  - dp_done is ignored in every state other than WAIT.
- OUT:
  - out_valid=1; out_result and out_count are stable until the handshake completes.
  - On out_ready=1: clear all lanes to 0, set count=0 and out_valid=0, go to FILL.
  - No bypass: the next vector is not accepted in the handshake cycle.
- dp_a and dp_b:
  - Driven directly from the lane registers.
  - Stable from START through OUT.
- Latency with a single-cycle-registered downstream and out_ready held at 1:
  - Last accept at edge t, dp_start high in cycle t+1, dp_done seen in cycle t+2, out_valid in cycle t+3.
  - Throughput is one vector per LANES+3 cycles.
- Arithmetic: the loader does no arithmetic. out_result is a bit-exact copy of dp_result, unsigned RES_W.
- Reset mid-operation: every state returns immediately to reset values. A partially filled vector and any pending result are discarded.
- in_valid=0 in FILL: hold; count and lanes are unchanged.

Optional Feature:
- Macro: DOT_LOADER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without dp_done, go to OUT with out_result=0, out_error=1 and out_count as recorded.
  - out_error clears with the out_ready handshake.
  - dp_done arriving in the same cycle as expiry wins: normal capture, out_error=0.
- Undefined:
  - No counter is built; out_error is tied to 0.
  - WAIT waits for dp_done indefinitely.

Test Plan:
- Full vector: 8 accepts with a=i+1, b=2, out_ready=1 -> one dp_start pulse; dp_a lane7=8; out_result=72, out_count=8, out_valid exactly 3 cycles after the last accept.
- Short vector: 3 accepts a=5, b=7, in_last on the 3rd -> lanes 3..7 of dp_a/dp_b=0; out_result=105, out_count=3.
- Backpressure: out_ready=0 for 10 cycles -> out_valid, out_result and out_count stable; in_ready=0 throughout; accepts resume only in the cycle after out_ready=1.
- Input stalls: in_valid toggling 1/0 over 8 elements a=b=1 -> only accepted beats stored; out_result=8.
- Reset mid-fill: 4 elements accepted, reset_n low for 1 cycle -> all outputs 0, in_ready=1; a fresh vector a=b=3 (8 beats) gives out_result=72, out_count=8.
- Watchdog (macro on, TIMEOUT_CYCLES=16): dp_done held 0 -> out_valid with out_error=1, out_result=0 exactly 16 cycles into WAIT. With macro off -> out_error never 1 and out_valid stays 0.
